// File: rtl/fft_pkg.sv
// Shared types and default sizing for the FFT frame sequencer.
// The state enum and parameter defaults live here so every block agrees on them.
package fft_pkg;

  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_N         = 9;
  localparam int DEF_FFT_SIZE  = 512;
  localparam int DEF_TIMEOUT   = 8192;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_READ,
    ST_FLUSH
  } fft_state_t;

  // Counter width able to hold timeout-1; never narrower than one bit.
  function automatic int wd_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/fft_seq_if.sv
// Control/status bundle between the frame sequencer and its surroundings
// (sample source, RAM load port, address controller, result consumer).
interface fft_seq_if import fft_pkg::*; #(
  parameter int N = DEF_N
);

  logic         enable;
  logic         sample_valid;
  logic         fft_done;
  logic         ovf_clr;

  logic         fft_load;
  logic [N-1:0] add_rd;
  logic         fft_start;
  logic         bf_enable;
  logic         rd_valid;
  logic [N-2:0] rd_bin;
  logic         frame_done;
  logic         busy;
  logic         overrun;
  logic         seq_err;

  // Sequencer side.
  modport master (
    input  enable, sample_valid, fft_done, ovf_clr,
    output fft_load, add_rd, fft_start, bf_enable, rd_valid, rd_bin,
           frame_done, busy, overrun, seq_err
  );

  // Environment side.
  modport slave (
    output enable, sample_valid, fft_done, ovf_clr,
    input  fft_load, add_rd, fft_start, bf_enable, rd_valid, rd_bin,
           frame_done, busy, overrun, seq_err
  );

endinterface

// File: rtl/fft_watchdog.sv
// Loadable down-counter guarding the butterfly phase: loaded with TIMEOUT-1,
// counts down while run is high, and strobes expired on the last allowed cycle.
module fft_watchdog import fft_pkg::*; #(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int W = wd_width(TIMEOUT);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= W'(TIMEOUT - 1);
    end else if (run && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign expired = run && (cnt_reg == '0);

endmodule

// File: rtl/fft_seq.sv
// Frame sequencer for an in-place FFT: loads FFT_SIZE samples, kicks the
// address controller, supervises the butterfly run and streams out half the bins.
module fft_seq import fft_pkg::*; #(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int N         = DEF_N,
  parameter int FFT_SIZE  = DEF_FFT_SIZE,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  fft_seq_if.master   bus
);

  localparam logic [N-1:0] LAST_LOAD = N'(FFT_SIZE - 1);
  localparam logic [N-2:0] LAST_BIN  = (N-1)'(FFT_SIZE / 2 - 1);

  // The datapath width only matters to the RAM and butterfly, not to sequencing.
  logic unused_bit_width;
  assign unused_bit_width = (BIT_WIDTH > 0);

  fft_state_t   state_reg, state_next;
  logic [N-1:0] load_cnt_reg, load_cnt_next;
  logic [N-2:0] rd_cnt_reg, rd_cnt_next;
  logic [N-2:0] rd_bin_reg;
  logic         rd_valid_reg;
  logic         abort_reg, abort_next;
  logic         overrun_reg, overrun_next;
  logic         seq_err_reg, seq_err_next;

  logic fft_load, fft_start, bf_enable, frame_done;
  logic wd_load, wd_run, wd_expired;
  logic drop;

  assign wd_load = (state_reg == ST_START);
  assign wd_run  = (state_reg == ST_RUN);

  fft_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .load    (wd_load),
    .run     (wd_run),
    .expired (wd_expired)
  );

  always_comb begin
    state_next    = state_reg;
    load_cnt_next = load_cnt_reg;
    rd_cnt_next   = rd_cnt_reg;
    abort_next    = abort_reg;
    seq_err_next  = seq_err_reg;
    fft_load      = 1'b0;
    fft_start     = 1'b0;
    bf_enable     = 1'b0;
    frame_done    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.enable) begin
          state_next    = ST_LOAD;
          load_cnt_next = '0;
        end
      end

      ST_LOAD: begin
        if (bus.sample_valid) begin
          fft_load = 1'b1;
          if (load_cnt_reg == LAST_LOAD) begin
            load_cnt_next = '0;
            state_next    = ST_START;
          end else begin
            load_cnt_next = load_cnt_reg + N'(1);
          end
        end
      end

      ST_START: begin
        fft_start  = 1'b1;
        state_next = ST_RUN;
      end

      ST_RUN: begin
        bf_enable = 1'b1;
        if (bus.fft_done) begin
          state_next  = ST_READ;
          rd_cnt_next = '0;
          abort_next  = 1'b0;
        end else if (wd_expired) begin
          seq_err_next = 1'b1;
          state_next   = ST_IDLE;
        end
      end

      ST_READ: begin
        rd_cnt_next = rd_cnt_reg + (N-1)'(1);
        if (rd_cnt_reg == LAST_BIN) begin
          state_next = ST_FLUSH;
        end else if (!bus.fft_done) begin
          // Results vanished mid-stream: finish the pending read but do not claim a frame.
          seq_err_next = 1'b1;
          abort_next   = 1'b1;
          state_next   = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        frame_done = !abort_reg;
        if (bus.enable) begin
          state_next    = ST_LOAD;
          load_cnt_next = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A drop always sets the flag, even when a clear arrives in the same cycle.
  assign drop         = bus.sample_valid && (state_reg != ST_LOAD);
  assign overrun_next = drop | (overrun_reg & ~bus.ovf_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      load_cnt_reg <= '0;
      rd_cnt_reg   <= '0;
      rd_bin_reg   <= '0;
      rd_valid_reg <= 1'b0;
      abort_reg    <= 1'b0;
      overrun_reg  <= 1'b0;
      seq_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      load_cnt_reg <= load_cnt_next;
      rd_cnt_reg   <= rd_cnt_next;
      rd_bin_reg   <= rd_cnt_reg;
      rd_valid_reg <= (state_reg == ST_READ);
      abort_reg    <= abort_next;
      overrun_reg  <= overrun_next;
      seq_err_reg  <= seq_err_next;
    end
  end

  assign bus.fft_load   = fft_load;
  assign bus.add_rd     = load_cnt_reg;
  assign bus.fft_start  = fft_start;
  assign bus.bf_enable  = bf_enable;
  assign bus.rd_valid   = rd_valid_reg;
  assign bus.rd_bin     = rd_bin_reg;
  assign bus.frame_done = frame_done;
  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.overrun    = overrun_reg;
  assign bus.seq_err    = seq_err_reg;

endmodule

// File: tb/tb_fft_seq.sv
// Directed-random bench for fft_seq: a full-size instance for frame flow,
// drops and reset, and a small instance with a short watchdog for error paths.
module tb_fft_seq;
  import fft_pkg::*;

  localparam int N1  = 9;
  localparam int FS1 = 512;
  localparam int BW1 = N1 - 1;
  localparam int N2  = 4;
  localparam int FS2 = 16;
  localparam int TO2 = 64;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic reset2 = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fft_seq_if #(.N(N1)) bus ();
  fft_seq_if #(.N(N2)) bus2 ();

  fft_seq #(
    .BIT_WIDTH (16),
    .N         (N1),
    .FFT_SIZE  (FS1),
    .TIMEOUT   (8192)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fft_seq #(
    .BIT_WIDTH (16),
    .N         (N2),
    .FFT_SIZE  (FS2),
    .TIMEOUT   (TO2)
  ) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Natural-order load model: the i-th accepted sample must carry index i.
  task automatic load_phase(input int n, input int gmin, input int gmax);
    int loads = 0;
    int order_err = 0;
    int spurious = 0;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (i == 0) ? 1 : int'($urandom_range(gmax, gmin));
      for (int j = 1; j < g; j++) begin
        @(negedge clk);
        bus.sample_valid = 1'b0;
        #1;
        if (bus.fft_load !== 1'b0) spurious++;
      end
      @(negedge clk);
      bus.sample_valid = 1'b1;
      #1;
      if (bus.fft_load === 1'b1) loads++;
      if (bus.add_rd !== N1'(i)) order_err++;
    end
    chk("load_count", loads, n);
    chk("add_rd_order", order_err, 0);
    chk("load_quiet_between", spurious, 0);
    $display("load: samples=%0d fft_load=%0d order_errors=%0d", n, loads, order_err);
  endtask

  task automatic start_check();
    @(negedge clk);
    bus.sample_valid = 1'b0;
    #1;
    chk("fft_start_after_last_load", bus.fft_start, 1);
    chk("start_no_bf_enable", bus.bf_enable, 0);
    chk("start_no_fft_load", bus.fft_load, 0);
    $display("start: fft_start=%0b", bus.fft_start);
  endtask

  // fft_done model: rises on the d-th RUN cycle after the start pulse.
  task automatic run_phase(input int d, input bit inject, input bit drop_en);
    int bf = 0;
    int starts = 0;
    for (int k = 1; k <= d; k++) begin
      @(negedge clk);
      if (bus.bf_enable === 1'b1) bf++;
      if (bus.fft_start !== 1'b0) starts++;
      if (inject) begin
        case (k)
          3: chk("overrun_clear_before_drop", bus.overrun, 0);
          4: begin bus.sample_valid = 1'b1; #1; chk("run_drop_no_load", bus.fft_load, 0); end
          5: begin bus.sample_valid = 1'b0; chk("run_drop_overrun", bus.overrun, 1); end
          6: begin bus.sample_valid = 1'b1; bus.ovf_clr = 1'b1; end
          7: begin bus.sample_valid = 1'b0; bus.ovf_clr = 1'b0; chk("drop_beats_clear", bus.overrun, 1); end
          8: bus.ovf_clr = 1'b1;
          9: begin bus.ovf_clr = 1'b0; chk("ovf_clr_alone", bus.overrun, 0); end
          default: ;
        endcase
      end
      if (drop_en && k == 3) bus.enable = 1'b0;
      if (k == d) bus.fft_done = 1'b1;
    end
    chk("bf_enable_cycles", bf, d);
    chk("no_restart_in_run", starts, 0);
    $display("run: cycles=%0d bf_enable=%0d inject=%0b enable_drop=%0b", d, bf, inject, drop_en);
  endtask

  task automatic read_phase(input int nb, input bit drop_en_at_flush);
    int nvalid = 0;
    int bin_err = 0;
    int fd = 0;
    int fd_pos = 0;
    int gaps = 0;
    int bf = 0;
    bit started = 1'b0;
    bit stop = 1'b0;
    for (int c = 0; c < nb + 20 && !stop; c++) begin
      @(negedge clk);
      if (bus.bf_enable === 1'b1) bf++;
      if (bus.rd_valid === 1'b1) begin
        if (bus.rd_bin !== BW1'(nvalid)) bin_err++;
        nvalid++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      if (bus.frame_done === 1'b1) begin
        fd++;
        fd_pos = nvalid;
        stop = 1'b1;
        bus.fft_done = 1'b0;
        if (drop_en_at_flush) bus.enable = 1'b0;
      end
    end
    chk("rd_valid_count", nvalid, nb);
    chk("rd_bin_order", bin_err, 0);
    chk("rd_valid_gaps", gaps, 0);
    chk("frame_done_count", fd, 1);
    chk("frame_done_on_last_bin", fd_pos, nb);
    chk("bf_off_in_read", bf, 0);
    @(negedge clk);
    chk("frame_done_single_cycle", bus.frame_done, 0);
    $display("read: valid=%0d bin_errors=%0d frame_done=%0d at_bin=%0d", nvalid, bin_err, fd, fd_pos);
  endtask

  task automatic d2_load_start();
    @(negedge clk);
    bus2.enable = 1'b1;
    for (int i = 0; i < FS2; i++) begin
      @(negedge clk);
      bus2.sample_valid = 1'b1;
    end
    @(negedge clk);
    bus2.sample_valid = 1'b0;
    bus2.enable = 1'b0;
    chk("d2_fft_start", bus2.fft_start, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    bad++;
    $fatal(1, "bench did not finish");
  end

  initial begin
    bus.enable = 1'b0;  bus.sample_valid = 1'b0;  bus.fft_done = 1'b0;  bus.ovf_clr = 1'b0;
    bus2.enable = 1'b0; bus2.sample_valid = 1'b0; bus2.fft_done = 1'b0; bus2.ovf_clr = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_add_rd", bus.add_rd, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_seq_err", bus.seq_err, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_bin", bus.rd_bin, 0);
    chk("rst_fft_start", bus.fft_start, 0);
    chk("rst_bf_enable", bus.bf_enable, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    $display("reset: busy=%0b overrun=%0b seq_err=%0b", bus.busy, bus.overrun, bus.seq_err);
    reset = 1'b0;
    reset2 = 1'b0;
    bus.enable = 1'b1;

    // Frame 1: strobe every 3 cycles, results 2000 cycles after start.
    load_phase(FS1, 3, 3);
    start_check();
    run_phase(2000, 1'b0, 1'b0);
    read_phase(FS1 / 2, 1'b0);

    // Frame 2: back-to-back, drops during RUN, enable dropped mid-frame.
    load_phase(FS1, 2, 4);
    start_check();
    run_phase(int'($urandom_range(120, 30)), 1'b1, 1'b1);
    read_phase(FS1 / 2, 1'b0);
    chk("idle_after_enable_drop", bus.busy, 0);
    repeat (3) @(negedge clk);
    chk("stays_idle", bus.busy, 0);
    $display("idle: busy=%0b", bus.busy);

    // Drop in IDLE, then reset in the middle of a load.
    @(negedge clk);
    bus.sample_valid = 1'b1;
    #1;
    chk("idle_drop_no_load", bus.fft_load, 0);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    chk("idle_drop_overrun", bus.overrun, 1);
    bus.enable = 1'b1;
    load_phase(300, 2, 3);
    @(negedge clk);
    chk("add_rd_before_reset", bus.add_rd, 300);
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    #1;
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_add_rd", bus.add_rd, 0);
    chk("midreset_overrun", bus.overrun, 0);
    chk("midreset_fft_load", bus.fft_load, 0);
    chk("midreset_rd_valid", bus.rd_valid, 0);
    $display("midreset: busy=%0b add_rd=%0d overrun=%0b", bus.busy, bus.add_rd, bus.overrun);
    @(negedge clk);
    reset = 1'b0;
    load_phase(FS1, 2, 3);
    start_check();
    run_phase(int'($urandom_range(80, 20)), 1'b0, 1'b0);
    read_phase(FS1 / 2, 1'b1);
    chk("idle_after_last_frame", bus.busy, 0);

    // Small instance: results withdrawn early in READ.
    chk("d2_seq_err_initial", bus2.seq_err, 0);
    d2_load_start();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus2.fft_done = (k == 5);
    end
    begin
      int v = 0;
      int fd = 0;
      for (int r = 1; r <= 20; r++) begin
        @(negedge clk);
        if (bus2.rd_valid === 1'b1) v++;
        if (bus2.frame_done === 1'b1) fd++;
        if (r == 3) bus2.fft_done = 1'b0;
      end
      chk("d2_abort_valids", v, 3);
      chk("d2_abort_no_frame_done", fd, 0);
      chk("d2_abort_seq_err", bus2.seq_err, 1);
      chk("d2_abort_idle", bus2.busy, 0);
      $display("abort: valid=%0d frame_done=%0d seq_err=%0b", v, fd, bus2.seq_err);
    end

    @(negedge clk);
    reset2 = 1'b1;
    #1;
    chk("d2_reset_clears_seq_err", bus2.seq_err, 0);
    @(negedge clk);
    reset2 = 1'b0;

    // Small instance: fft_done never arrives.
    d2_load_start();
    begin
      int bf = 0;
      int fd = 0;
      for (int c = 0; c < TO2 + 30; c++) begin
        @(negedge clk);
        if (bus2.bf_enable === 1'b1) bf++;
        if (bus2.frame_done === 1'b1) fd++;
        if (c == 10) chk("d2_seq_err_before_timeout", bus2.seq_err, 0);
      end
      chk("d2_timeout_run_cycles", bf, TO2);
      chk("d2_timeout_seq_err", bus2.seq_err, 1);
      chk("d2_timeout_idle", bus2.busy, 0);
      chk("d2_timeout_no_frame_done", fd, 0);
      $display("timeout: run_cycles=%0d seq_err=%0b busy=%0b", bf, bus2.seq_err, bus2.busy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
